// File: rtl/mult_booth_seq.sv
// Sequential signed 32x32 multiplier using radix-4 modified Booth recoding.
// Retires two multiplier bits per RUN cycle; a result is ready 17 edges after start.
module mult_booth_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic        busy,
  output logic        ready,
  output logic [31:0] product,
  output logic [31:0] product_hi,
  output logic        exception
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [33:0] r_m;
  logic [33:0] r_a;
  logic [31:0] r_q;
  logic        r_qm1;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic        r_ready;
  logic [31:0] r_prod_lo;
  logic [31:0] r_prod_hi;
  logic        r_exc;

  logic [2:0]  w_trip;
  logic [33:0] w_sel;
  logic        w_neg;
  logic [33:0] w_addend;
  logic [33:0] w_a_new;
  logic [33:0] w_a_sh;
  logic [31:0] w_q_sh;
  logic [63:0] w_full;
  logic        w_exc;

  // Booth step: pick 0/+-M/+-2M from the recoded triplet, add, then shift the
  // whole {A,Q,q_-1} chain right by two with A's sign filling from the top.
  always_comb begin
    w_trip = {r_q[1:0], r_qm1};
    w_sel  = '0;
    w_neg  = 1'b0;
    case (w_trip)
      3'b001, 3'b010: w_sel = r_m;
      3'b011:         w_sel = {r_m[32:0], 1'b0};
      3'b100: begin
        w_sel = {r_m[32:0], 1'b0};
        w_neg = 1'b1;
      end
      3'b101, 3'b110: begin
        w_sel = r_m;
        w_neg = 1'b1;
      end
      default: w_sel = '0;
    endcase
    w_addend = w_neg ? ~w_sel : w_sel;
    w_a_new  = r_a + w_addend + {33'd0, w_neg};
    w_a_sh   = {{2{w_a_new[33]}}, w_a_new[33:2]};
    w_q_sh   = {w_a_new[1:0], r_q[31:2]};
    w_full   = {w_a_sh[31:0], w_q_sh};
    // Fits in signed 32 bits only when bits 63..31 are all copies of the sign.
    w_exc    = ~((&w_full[63:31]) | ~(|w_full[63:31]));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_m       <= '0;
      r_a       <= '0;
      r_q       <= '0;
      r_qm1     <= 1'b0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_ready   <= 1'b0;
      r_prod_lo <= '0;
      r_prod_hi <= '0;
      r_exc     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_ready <= 1'b0;
          if (start) begin
            r_m     <= {{2{multiplicand[31]}}, multiplicand};
            r_q     <= multiplier;
            r_a     <= '0;
            r_qm1   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a   <= w_a_sh;
          r_q   <= w_q_sh;
          r_qm1 <= r_q[1];
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_prod_lo <= w_full[31:0];
            r_prod_hi <= w_full[63:32];
            r_exc     <= w_exc;
            r_busy    <= 1'b0;
            r_ready   <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_ready <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign ready      = r_ready;
  assign product    = r_prod_lo;
  assign product_hi = r_prod_hi;
  assign exception  = r_exc;

endmodule
